// File: rtl/tap_pkg.sv
// Shared TAP definitions: 1149.1 state encoding, the TMS transition graph
// and the fixed BYPASS opcode.
package tap_pkg;

   typedef enum logic [3:0] {
      EXIT2_DR         = 4'h0,
      EXIT1_DR         = 4'h1,
      SHIFT_DR         = 4'h2,
      PAUSE_DR         = 4'h3,
      SELECT_IR        = 4'h4,
      UPDATE_DR        = 4'h5,
      CAPTURE_DR       = 4'h6,
      SELECT_DR        = 4'h7,
      EXIT2_IR         = 4'h8,
      EXIT1_IR         = 4'h9,
      SHIFT_IR         = 4'hA,
      PAUSE_IR         = 4'hB,
      RUN_IDLE         = 4'hC,
      UPDATE_IR        = 4'hD,
      CAPTURE_IR       = 4'hE,
      TEST_LOGIC_RESET = 4'hF
   } tap_state_t;

   // All-ones at any IR width; the top truncates this to IR_LEN bits.
   localparam logic [31:0] BYPASS_OPCODE = 32'hFFFF_FFFF;
   localparam int IDCODE_W = 32;

   function automatic tap_state_t next_state(input tap_state_t s, input logic tms);
      case (s)
         TEST_LOGIC_RESET: next_state = tms ? TEST_LOGIC_RESET : RUN_IDLE;
         RUN_IDLE:         next_state = tms ? SELECT_DR : RUN_IDLE;
         SELECT_DR:        next_state = tms ? SELECT_IR : CAPTURE_DR;
         CAPTURE_DR:       next_state = tms ? EXIT1_DR : SHIFT_DR;
         SHIFT_DR:         next_state = tms ? EXIT1_DR : SHIFT_DR;
         EXIT1_DR:         next_state = tms ? UPDATE_DR : PAUSE_DR;
         PAUSE_DR:         next_state = tms ? EXIT2_DR : PAUSE_DR;
         EXIT2_DR:         next_state = tms ? UPDATE_DR : SHIFT_DR;
         UPDATE_DR:        next_state = tms ? SELECT_DR : RUN_IDLE;
         SELECT_IR:        next_state = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
         CAPTURE_IR:       next_state = tms ? EXIT1_IR : SHIFT_IR;
         SHIFT_IR:         next_state = tms ? EXIT1_IR : SHIFT_IR;
         EXIT1_IR:         next_state = tms ? UPDATE_IR : PAUSE_IR;
         PAUSE_IR:         next_state = tms ? EXIT2_IR : PAUSE_IR;
         EXIT2_IR:         next_state = tms ? UPDATE_IR : SHIFT_IR;
         UPDATE_IR:        next_state = tms ? SELECT_DR : RUN_IDLE;
         default:          next_state = TEST_LOGIC_RESET;
      endcase
   endfunction

endpackage

// File: rtl/tap_fsm.sv
// 16-state TAP state register; TRST forces Test-Logic-Reset synchronously.
module tap_fsm
   import tap_pkg::*;
(
   input  logic       TCK,
   input  logic       TRST,
   input  logic       TMS,
   output tap_state_t tap_state
);

   tap_state_t state_q;
   tap_state_t state_d;

   always_ff @(posedge TCK) begin
      if (!TRST) state_q <= TEST_LOGIC_RESET;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      state_d = next_state(state_q, TMS);
   end

   assign tap_state = state_q;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: IR, IDCODE/BYPASS registers, user-chain decode
// and registered TDO mux.
module jtag_tap_ctrl
   import tap_pkg::*;
#(
   parameter int                 IR_LEN     = 4,
   parameter int                 NUM_CHAINS = 2,
   parameter logic [31:0]        IDCODE_VAL = 32'h1000_0001,
   parameter logic [IR_LEN-1:0]  IDCODE_OP  = {{(IR_LEN-1){1'b1}}, 1'b0}
) (
   input  logic                  TCK,
   input  logic                  TRST,
   input  logic                  TMS,
   input  logic                  TDI,
   input  logic [NUM_CHAINS-1:0] chain_tdo,
   output logic                  tdo,
   output logic                  tdo_en,
   output logic [3:0]            tap_state,
   output logic [NUM_CHAINS-1:0] chain_sel,
   output logic                  capture_dr,
   output logic                  shift_dr,
   output logic                  update_dr,
   output logic                  select_ir
);

   localparam logic [IR_LEN-1:0] BYPASS_OP = IR_LEN'(BYPASS_OPCODE);

   if (IR_LEN < 2) begin : g_bad_ir_len
      $error("jtag_tap_ctrl: IR_LEN must be at least 2");
   end
   if (NUM_CHAINS < 1 || NUM_CHAINS > (1 << IR_LEN) - 2) begin : g_bad_chains
      $error("jtag_tap_ctrl: NUM_CHAINS out of range");
   end
   if (IDCODE_VAL[0] != 1'b1) begin : g_bad_idcode
      $error("jtag_tap_ctrl: IDCODE_VAL bit 0 must be 1");
   end
   if (IDCODE_OP == BYPASS_OP || int'(IDCODE_OP) < NUM_CHAINS) begin : g_bad_idcode_op
      $error("jtag_tap_ctrl: IDCODE_OP collides with BYPASS or a chain opcode");
   end

   tap_state_t                state;
   tap_state_t                nstate;
   logic [IR_LEN-1:0]         ir, ir_d;
   logic [IR_LEN-1:0]         ir_sr, ir_sr_d;
   logic [IDCODE_W-1:0]       idcode_sr, idcode_d;
   logic                      bypass_q, bypass_d;
   logic                      tdo_d, tdo_en_d;
   logic                      sel_idcode, sel_chain, sel_bypass, chain_bit;

   tap_fsm u_fsm (
      .TCK       (TCK),
      .TRST      (TRST),
      .TMS       (TMS),
      .tap_state (state)
   );

   // Mirror of the FSM's next state so TDO can be registered for the state being entered.
   assign nstate    = TRST ? next_state(state, TMS) : TEST_LOGIC_RESET;
   assign tap_state = state;

   always_comb begin
      chain_sel = '0;
      for (int k = 0; k < NUM_CHAINS; k++) begin
         if (ir == IR_LEN'(k)) chain_sel[k] = 1'b1;
      end
   end

   assign sel_chain  = |chain_sel;
   assign sel_idcode = (ir == IDCODE_OP);
   assign sel_bypass = !sel_chain && !sel_idcode;
   assign chain_bit  = |(chain_sel & chain_tdo);

   assign capture_dr = (state == CAPTURE_DR) && sel_chain;
   assign shift_dr   = (state == SHIFT_DR)   && sel_chain;
   assign update_dr  = (state == UPDATE_DR)  && sel_chain;

   always_comb begin
      case (state)
         SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR,
         PAUSE_IR, EXIT2_IR, UPDATE_IR: select_ir = 1'b1;
         default:                       select_ir = 1'b0;
      endcase
   end

   always_comb begin
      ir_d     = ir;
      ir_sr_d  = ir_sr;
      idcode_d = idcode_sr;
      bypass_d = bypass_q;
      case (state)
         CAPTURE_IR: ir_sr_d = IR_LEN'(2'b01);
         SHIFT_IR:   ir_sr_d = {TDI, ir_sr[IR_LEN-1:1]};
         UPDATE_IR:  ir_d    = ir_sr;
         CAPTURE_DR: begin
            if (sel_idcode) idcode_d = IDCODE_VAL;
            if (sel_bypass) bypass_d = 1'b0;
         end
         SHIFT_DR: begin
            if (sel_idcode) idcode_d = {TDI, idcode_sr[IDCODE_W-1:1]};
            if (sel_bypass) bypass_d = TDI;
         end
         default: ;
      endcase
      // Every cycle spent in Test-Logic-Reset reinitialises the registers.
      if (nstate == TEST_LOGIC_RESET) begin
         ir_d     = IDCODE_OP;
         ir_sr_d  = '0;
         idcode_d = IDCODE_VAL;
         bypass_d = 1'b0;
      end
      tdo_d    = 1'b0;
      tdo_en_d = 1'b0;
      if (nstate == SHIFT_IR) begin
         tdo_d    = ir_sr_d[0];
         tdo_en_d = 1'b1;
      end else if (nstate == SHIFT_DR) begin
         tdo_en_d = 1'b1;
         if (sel_chain)       tdo_d = chain_bit;
         else if (sel_idcode) tdo_d = idcode_d[0];
         else                 tdo_d = bypass_d;
      end
   end

   always_ff @(posedge TCK) begin
      if (!TRST) begin
         ir        <= IDCODE_OP;
         ir_sr     <= '0;
         idcode_sr <= IDCODE_VAL;
         bypass_q  <= 1'b0;
         tdo       <= 1'b0;
         tdo_en    <= 1'b0;
      end else begin
         ir        <= ir_d;
         ir_sr     <= ir_sr_d;
         idcode_sr <= idcode_d;
         bypass_q  <= bypass_d;
         tdo       <= tdo_d;
         tdo_en    <= tdo_en_d;
      end
   end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Bench for jtag_tap_ctrl: table-driven TAP model checked every cycle, plus
// directed scans with hand-computed expectations and a random TMS/TRST walk.
module tb_jtag_tap_ctrl;

   localparam int          IR_LEN = 4;
   localparam int          NC     = 2;
   localparam logic [31:0] IDV    = 32'h1000_0001;
   localparam logic [3:0]  IDOP   = 4'hE;

   logic          TCK = 1'b0;
   logic          TRST, TMS, TDI;
   logic [NC-1:0] chain_tdo;
   logic          tdo, tdo_en, capture_dr, shift_dr, update_dr, select_ir;
   logic [3:0]    tap_state;
   logic [NC-1:0] chain_sel;

   jtag_tap_ctrl #(
      .IR_LEN(IR_LEN), .NUM_CHAINS(NC), .IDCODE_VAL(IDV), .IDCODE_OP(IDOP)
   ) dut (
      .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .chain_tdo(chain_tdo),
      .tdo(tdo), .tdo_en(tdo_en), .tap_state(tap_state), .chain_sel(chain_sel),
      .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
      .select_ir(select_ir)
   );

   always #5 TCK = ~TCK;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // TMS graph as lookup tables indexed by 4-bit state code.
   int nxt0 [16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
   int nxt1 [16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};
   logic [15:0] ir_col = 16'h6F10;

   int          mst   = 15;
   int unsigned mir   = IDOP;
   int unsigned mirsr = 0;
   int unsigned mid   = IDV;
   int unsigned mbyp  = 0;
   int unsigned mtdo  = 0;
   int unsigned mtdo_en = 0;

   function automatic bit m_chain();
      return mir < NC;
   endfunction

   function automatic bit m_id();
      return mir == IDOP;
   endfunction

   task automatic model_step(input logic tms, input logic tdi, input logic trst,
                             input logic [NC-1:0] ct);
      int ns;
      ns = !trst ? 15 : (tms ? nxt1[mst] : nxt0[mst]);
      if (trst) begin
         case (mst)
            14: mirsr = 1;
            10: mirsr = (mirsr >> 1) + (tdi ? (1 << (IR_LEN - 1)) : 0);
            13: mir = mirsr;
            6:  if (m_id()) mid = IDV; else if (!m_chain()) mbyp = 0;
            2:  if (m_id()) mid = (mid >> 1) + (tdi ? 32'h8000_0000 : 0);
                else if (!m_chain()) mbyp = tdi;
            default: ;
         endcase
      end
      if (ns == 15) begin
         mir = IDOP; mirsr = 0; mid = IDV; mbyp = 0;
      end
      mst = ns;
      mtdo_en = (mst == 10 || mst == 2);
      mtdo = 0;
      if (mst == 10) mtdo = mirsr % 2;
      else if (mst == 2) begin
         if (m_chain())   mtdo = (ct >> mir) & 1;
         else if (m_id()) mtdo = mid % 2;
         else             mtdo = mbyp;
      end
   endtask

   always @(negedge TCK) begin
      if (chk_en) begin
         int unsigned esel;
         esel = m_chain() ? (1 << mir) : 0;
         check("tap_state",  tap_state,  mst);
         check("tdo",        tdo,        mtdo);
         check("tdo_en",     tdo_en,     mtdo_en);
         check("chain_sel",  chain_sel,  esel);
         check("capture_dr", capture_dr, (mst == 6) && esel != 0);
         check("shift_dr",   shift_dr,   (mst == 2) && esel != 0);
         check("update_dr",  update_dr,  (mst == 5) && esel != 0);
         check("select_ir",  select_ir,  ir_col[mst]);
      end
   end

   task automatic tick();
      @(posedge TCK);
      model_step(TMS, TDI, TRST, chain_tdo);
      #1;
   endtask

   task automatic drive(input logic tms, input logic tdi, input logic trst,
                        input logic [NC-1:0] ct);
      TMS = tms; TDI = tdi; TRST = trst; chain_tdo = ct;
      tick();
   endtask

   task automatic step(input logic tms, input logic tdi);
      drive(tms, tdi, 1'b1, NC'($urandom));
   endtask

   task automatic load_ir(input logic [3:0] op, output logic [3:0] cap);
      step(1, 0); step(1, 0); step(0, 0); step(0, 0);
      for (int i = 0; i < IR_LEN; i++) begin
         cap[i] = tdo;
         step(i == IR_LEN - 1, op[i]);
      end
      step(1, 0); step(0, 0);
   endtask

   task automatic shift_dr8(input logic [7:0] d, output logic [8:0] got);
      step(1, 0); step(0, 0); step(0, 0);
      for (int i = 0; i < 9; i++) begin
         got[i] = tdo;
         step(i == 8, (i < 8) ? d[i] : 1'b0);
      end
      step(1, 0); step(0, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] idbits;
      logic [3:0]  cap;
      logic [8:0]  got;
      int          cnt;

      TRST = 1'b0; TMS = 1'b0; TDI = 1'b0; chain_tdo = '0;
      @(negedge TCK);
      drive(1'($urandom), 1'($urandom), 1'b0, NC'($urandom));
      chk_en = 1;
      check("rst_state",  tap_state, 4'hF);
      check("rst_tdo_en", tdo_en,    1'b0);
      check("rst_chain",  chain_sel, 2'b00);

      // IDCODE readout straight after reset
      step(0, 0); step(1, 0); step(0, 0); step(0, 0);
      for (int i = 0; i < 32; i++) begin
         idbits[i] = tdo;
         step(i == 31, 1'($urandom));
      end
      step(1, 0); step(0, 0);
      check("idcode", idbits, 32'h1000_0001);

      load_ir(4'h0, cap);
      check("ir_capture", cap, 4'b0001);
      check("ir0_chain_sel", chain_sel, 2'b01);

      // Five TMS=1 from Pause-IR
      step(1, 0); step(1, 0); step(0, 0); step(0, 0); step(1, 0); step(0, 0);
      check("pause_ir", tap_state, 4'hB);
      for (int i = 0; i < 4; i++) step(1, 0);
      check("tms4_not_tlr", tap_state == 4'hF, 1'b0);
      step(1, 0);
      check("tms5_tlr", tap_state, 4'hF);
      step(0, 0);

      load_ir(4'hF, cap);
      shift_dr8(8'hA5, got);
      check("bypass_F", got, 9'h14A);
      load_ir(4'h5, cap);
      shift_dr8(8'hA5, got);
      check("bypass_5", got, 9'h14A);

      // User chain 1: three Shift-DR cycles, TDO follows chain_tdo[1]
      load_ir(4'h1, cap);
      check("ir1_chain_sel", chain_sel, 2'b10);
      step(1, 0); step(0, 0);
      check("chain_capture", capture_dr, 1'b1);
      cnt = 0;
      drive(0, 0, 1, 2'b10); cnt += int'(shift_dr); check("chain_tdo_a", tdo, 1'b1);
      drive(0, 0, 1, 2'b01); cnt += int'(shift_dr); check("chain_tdo_b", tdo, 1'b0);
      drive(0, 0, 1, 2'b10); cnt += int'(shift_dr); check("chain_tdo_c", tdo, 1'b1);
      step(1, 0); cnt += int'(shift_dr);
      check("shift_dr_cycles", cnt, 3);
      step(1, 0);
      check("chain_update", update_dr, 1'b1);
      step(0, 0);

      // TRST during the second shift cycle
      step(1, 0); step(0, 0); step(0, 0); step(0, 0);
      drive(0, 0, 1'b0, 2'b11);
      check("trst_state", tap_state, 4'hF);
      cnt = int'(update_dr);
      step(1, 0); cnt += int'(update_dr);
      step(0, 0); cnt += int'(update_dr);
      check("trst_no_update", cnt, 0);
      check("trst_chain_sel", chain_sel, 2'b00);

      for (int i = 0; i < 3000; i++) begin
         drive(1'($urandom_range(0, 99) < 40), 1'($urandom),
               1'($urandom_range(0, 63) != 0), NC'($urandom));
      end

      chk_en = 0;
      @(negedge TCK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
